// File: rtl/modos_multicanal.sv
// N-channel need-level manager: saturating levels with timed decay, debounced increments,
// long-press strobes and a registered global exhaustion alarm.
module modos_multicanal #(
   parameter int unsigned N_CH     = 4,
   parameter int unsigned LVL_W    = 2,
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned TEST_DIV = 10,
   parameter int unsigned DECAY_S  = 10,
   parameter int unsigned HOLD_S   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  test,
   input  logic [N_CH-1:0]       inc,
   input  logic [N_CH-1:0]       activo,
   output logic [N_CH*LVL_W-1:0] nivel,
   output logic [N_CH-1:0]       senal_5seg,
   output logic [N_CH-1:0]       agotado,
   output logic                  alarma
);

   localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned DEC_W = (DECAY_S > 1) ? $clog2(DECAY_S) : 1;
   localparam int unsigned HLD_W = $clog2(HOLD_S + 1);

   localparam logic [CNT_W-1:0] LIM_NORM_M1 = CNT_W'(CLK_HZ - 1);
   localparam logic [CNT_W-1:0] LIM_TEST_M1 = CNT_W'(CLK_HZ / TEST_DIV - 1);
   localparam logic [LVL_W-1:0] LVL_MAX     = '1;
   localparam logic [DEC_W-1:0] DEC_LAST    = DEC_W'(DECAY_S - 1);
   localparam logic [HLD_W-1:0] HLD_LIM     = HLD_W'(HOLD_S);
   localparam logic [HLD_W-1:0] HLD_LAST    = HLD_W'(HOLD_S - 1);

   typedef enum logic {StVivo, StAgotado} est_e;

   logic [CNT_W-1:0] cnt_q, cnt_d, lim_m1;
   logic             seg_tick;
   logic [N_CH-1:0]  inc_q, subida, pulsado;

   logic [LVL_W-1:0] lvl_q  [N_CH];
   logic [LVL_W-1:0] lvl_d  [N_CH];
   logic [DEC_W-1:0] dcnt_q [N_CH];
   logic [DEC_W-1:0] dcnt_d [N_CH];
   logic [HLD_W-1:0] hold_q [N_CH];
   logic [HLD_W-1:0] hold_d [N_CH];
   logic [N_CH-1:0]  senal_q, senal_d;
   est_e             est_q  [N_CH];
   est_e             est_d  [N_CH];
   logic             alarma_q;

   // Using >= lets a shortened limit (test raised mid-count) fire once and clear.
   always_comb begin
      lim_m1   = test ? LIM_TEST_M1 : LIM_NORM_M1;
      seg_tick = (cnt_q >= lim_m1);
      cnt_d    = seg_tick ? '0 : cnt_q + 1'b1;
   end

   assign subida  = inc & ~inc_q;
   assign pulsado = inc & activo;

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         lvl_d[i]   = lvl_q[i];
         dcnt_d[i]  = dcnt_q[i];
         hold_d[i]  = hold_q[i];
         senal_d[i] = 1'b0;

         if (subida[i] && activo[i]) begin
            if (lvl_q[i] != LVL_MAX) lvl_d[i] = lvl_q[i] + 1'b1;
            dcnt_d[i] = '0;
         end else if (seg_tick) begin
            if (dcnt_q[i] == DEC_LAST) begin
               dcnt_d[i] = '0;
               if (lvl_q[i] != '0) lvl_d[i] = lvl_q[i] - 1'b1;
            end else begin
               dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
         end

         // Hold counts only full ticks after the press edge and saturates at HOLD_S.
         if (!pulsado[i] || subida[i]) begin
            hold_d[i] = '0;
         end else if (seg_tick && hold_q[i] < HLD_LIM) begin
            hold_d[i]  = hold_q[i] + 1'b1;
            senal_d[i] = (hold_q[i] == HLD_LAST);
         end
      end
   end

   // Per-channel liveness FSM: next state follows the next level.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         est_d[i] = est_q[i];
         unique case (est_q[i])
            StVivo:    if (lvl_d[i] == '0) est_d[i] = StAgotado;
            StAgotado: if (lvl_d[i] != '0) est_d[i] = StVivo;
            default:   est_d[i] = StVivo;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         inc_q    <= '0;
         senal_q  <= '0;
         alarma_q <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            lvl_q[i]  <= LVL_MAX;
            dcnt_q[i] <= '0;
            hold_q[i] <= '0;
            est_q[i]  <= StVivo;
         end
      end else begin
         cnt_q    <= cnt_d;
         inc_q    <= inc;
         senal_q  <= senal_d;
         alarma_q <= |agotado;
         for (int i = 0; i < N_CH; i++) begin
            lvl_q[i]  <= lvl_d[i];
            dcnt_q[i] <= dcnt_d[i];
            hold_q[i] <= hold_d[i];
            est_q[i]  <= est_d[i];
         end
      end
   end

   always_comb begin
      nivel   = '0;
      agotado = '0;
      for (int i = 0; i < N_CH; i++) begin
         nivel[i*LVL_W +: LVL_W] = lvl_q[i];
         agotado[i]              = (est_q[i] == StAgotado);
      end
   end

   assign senal_5seg = senal_q;
   assign alarma     = alarma_q;

endmodule

// File: tb/tb_modos_multicanal.sv
// Directed bench for modos_multicanal with shortened timing (20-cycle second, 5 in test mode).
module tb_modos_multicanal;

   logic       clk = 1'b0;
   logic       reset, test;
   logic [3:0] inc, activo;
   logic [7:0] nivel;
   logic [3:0] senal_5seg, agotado;
   logic       alarma;

   int n_asserts = 0;
   int n_fails   = 0;
   int pulses, first;

   modos_multicanal #(
      .N_CH(4), .LVL_W(2), .CLK_HZ(20), .TEST_DIV(4), .DECAY_S(3), .HOLD_S(2)
   ) dut (
      .clk(clk), .reset(reset), .test(test), .inc(inc), .activo(activo),
      .nivel(nivel), .senal_5seg(senal_5seg), .agotado(agotado), .alarma(alarma)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Samples senal_5seg[ch] for n cycles; pulse count and first pulse offset.
   task automatic watch(input int n, input int ch);
      pulses = 0;
      first  = 0;
      for (int i = 1; i <= n; i++) begin
         step(1);
         if (senal_5seg[ch]) begin
            pulses++;
            if (first == 0) first = i;
         end
      end
   endtask

   initial begin
      reset = 1'b1; test = 1'b0; inc = 4'h0; activo = 4'hF;
      step(2);
      chk("rst_nivel", 32'(nivel), 32'hFF);
      chk("rst_alarma", 32'(alarma), 0);
      chk("rst_senal", 32'(senal_5seg), 0);
      chk("rst_agotado", 32'(agotado), 0);
      reset = 1'b0;

      // Free decay in normal mode: one level per 60 cycles
      step(59);  chk("decay_pre60", 32'(nivel), 32'hFF);
      step(1);   chk("decay_60", 32'(nivel), 32'hAA);
      step(119); chk("decay_179", 32'(nivel), 32'h55);
      chk("alarma_179", 32'(alarma), 0);
      step(1);   chk("decay_180", 32'(nivel), 32'h00);
      chk("agotado_180", 32'(agotado), 32'hF);
      chk("alarma_lag", 32'(alarma), 0);
      step(1);   chk("alarma_181", 32'(alarma), 1);
      step(2000); chk("stay_zero", 32'(nivel), 32'h00);

      // Ch2 revives from zero, held input gives a single increment
      inc = 4'h4;
      step(1);   chk("ch2_inc", 32'(nivel), 32'h10);
      chk("ch2_agotado", 32'(agotado), 32'hB);
      step(9);   chk("ch2_held", 32'(nivel), 32'h10);
      chk("ch2_no_strobe", 32'(senal_5seg), 0);
      chk("alarma_others", 32'(alarma), 1);
      inc = 4'h0;

      // Increment coinciding with the ch2 decay tick wins and restarts the decay count
      step(48);  chk("pre_collide", 32'(nivel), 32'h10);
      inc = 4'h4;
      step(1);   chk("collide", 32'(nivel), 32'h20);
      inc = 4'h0;
      step(59);  chk("restart_2299", 32'(nivel), 32'h20);
      step(1);   chk("restart_2300", 32'(nivel), 32'h10);

      // Reset mid-count realigns prescaler and decay counters
      step(10);
      reset = 1'b1;
      step(2);
      chk("rst2_nivel", 32'(nivel), 32'hFF);
      chk("rst2_alarma", 32'(alarma), 0);
      chk("rst2_agotado", 32'(agotado), 0);
      reset = 1'b0;
      step(59);  chk("rst2_pre60", 32'(nivel), 32'hFF);
      step(1);   chk("rst2_60", 32'(nivel), 32'hAA);

      // Long press in test mode
      test = 1'b1; inc = 4'h1;
      step(1);   chk("hold_inc", 32'(nivel), 32'hAB);
      watch(29, 0);
      chk("hold_pulses", 32'(pulses), 1);
      chk("hold_first", 32'(first), 9);
      chk("hold_nivel", 32'(nivel), 32'h01);
      chk("hold_agotado", 32'(agotado), 32'hE);
      inc = 4'h0;
      step(2);
      inc = 4'h1;
      step(1);   chk("rearm_inc", 32'(nivel), 32'h02);
      watch(15, 0);
      chk("rearm_pulses", 32'(pulses), 1);
      chk("rearm_first", 32'(first), 7);
      chk("rearm_nivel", 32'(nivel), 32'h01);
      inc = 4'h0;

      // Ch3 disabled: inc and hold ignored, decay continues
      reset = 1'b1; activo = 4'h7;
      step(2);
      reset = 1'b0;
      step(15);  chk("off_decay", 32'(nivel), 32'hAA);
      inc = 4'h8;
      watch(12, 3);
      chk("off_held", 32'(nivel), 32'hAA);
      chk("off_pulses", 32'(pulses), 0);
      inc = 4'h0;
      step(1);
      inc = 4'h8;
      step(1);
      inc = 4'h0;
      step(1);   chk("off_decay2", 32'(nivel), 32'h55);

      // Toggle test mid-count: no missed or doubled second tick
      step(3);
      test = 1'b0;
      step(16);  chk("tog_49", 32'(nivel), 32'h55);
      step(11);
      test = 1'b1;
      step(1);   chk("tog_61", 32'(nivel), 32'h55);
      step(4);   chk("tog_65", 32'(nivel), 32'h55);
      chk("tog_65_ag", 32'(agotado), 0);
      step(1);   chk("tog_66", 32'(nivel), 32'h00);
      chk("tog_66_ag", 32'(agotado), 32'hF);
      chk("tog_66_al", 32'(alarma), 0);
      step(1);   chk("tog_67_al", 32'(alarma), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
